code_lock_ctrl: RTL and testbench
=================================

Name: code_lock_ctrl

Overview:
- Sequential controller that owns a 4-bit nibble equality comparator and schedules it over a serially entered code.
- Each entered digit is compared against the matching nibble of a stored key.
- A full matching sequence opens the lock for a timed window. Repeated failures force a timed alarm lockout.
- Sits between a keypad/debounce front end and the actuator/alarm drivers in the DigitalLogic design set.

Parameters:
- DIGITS, 4, code length in nibbles; legal range 2..8.
- KEY, 16'h5A3C, key packed 4*DIGITS bits wide; the first-entered digit is compared to KEY[3:0], the next to KEY[7:4], and so on.
- MAX_FAIL, 3, consecutive failed codes that trigger lockout; must be at least 1.
- UNLOCK_CYCLES, 8, clock cycles that unlocked stays high.
- LOCKOUT_CYCLES, 16, clock cycles spent in lockout with alarm high.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- digit_valid  input  1  one-cycle strobe; digit is accepted in that cycle.
- digit  input  4  entered nibble.
- clear  input  1  abandons the partial entry, or relocks early when open.
- ready  output  1  high only in the ENTRY state.
- unlocked  output  1  high for the whole OPEN state.
- alarm  output  1  high for the whole LOCKOUT state.
- err  output  1  one-cycle pulse when a complete code mismatches.
- digit_idx  output  $clog2(DIGITS)  index of the next digit to be accepted.
- fail_cnt  output  $clog2(MAX_FAIL+1)  current count of consecutive failures.

Behaviour:
- Reset (asynchronous, any state, including mid-entry): state=ENTRY, digit_idx=0, match_acc=1, fail_cnt=0, timer=0, ready=1, unlocked=0, alarm=0, err=0. When built with the option, key_reg is reset to KEY.
- States and transitions:
  - ENTRY:
    - clear: digit_idx=0, match_acc=1; fail_cnt is unchanged. clear has priority over digit_valid in the same cycle; that digit is dropped.
    - digit_valid, not the last digit: match_acc &= (digit == key nibble[digit_idx]), then digit_idx++.
    - A mismatch never aborts early. All DIGITS digits are always consumed, so the position of a wrong digit is not revealed.
    - digit_valid on the last digit (digit_idx == DIGITS-1), full match (match_acc && eq):
      - Next cycle: OPEN, unlocked=1, fail_cnt=0, timer=UNLOCK_CYCLES-1.
    - digit_valid on the last digit, any mismatch:
      - err=1 for exactly the next cycle; digit_idx=0, match_acc=1.
      - fail_cnt+1 == MAX_FAIL: go to LOCKOUT, fail_cnt=MAX_FAIL, timer=LOCKOUT_CYCLES-1.
      - Otherwise: fail_cnt++ and stay in ENTRY.
  - OPEN:
    - digit_valid is ignored.
    - Timer decrements each cycle. At timer==0, or on clear, go to ENTRY next cycle with digit_idx=0.
    - unlocked is high for exactly UNLOCK_CYCLES cycles unless cleared early.
  - LOCKOUT:
    - digit_valid and clear are both ignored.
    - Timer decrements each cycle. At timer==0, go to ENTRY with fail_cnt=0.
    - alarm is high for exactly LOCKOUT_CYCLES cycles.
- Latency: unlocked, err and alarm all assert on the first rising edge after the last digit's strobe edge.
- State encoding: ENTRY, OPEN and LOCKOUT are one-hot exclusive. ready, unlocked and alarm are never high together.
- All outputs are registered; none are combinational from inputs.

Optional Feature:
- Macro LOCK_KEY_LOAD_EN.
- Defined:
  - Adds input key_we (1 bit) and input key_in (4*DIGITS bits).
  - Comparisons use key_reg, which resets to KEY.
  - key_we is honoured only in OPEN: key_reg <= key_in, and the lock relocks to ENTRY the next cycle.
  - key_we in ENTRY or LOCKOUT is ignored.
- Undefined: ports are absent and the comparison nibbles come directly from the KEY parameter.

Test Plan:
- Correct code (defaults): strobe digits C,3,A,5 on 4 separate cycles -> unlocked=1 one cycle after the 4th strobe, for exactly 8 cycles, then ready=1, digit_idx=0.
- Single wrong digit: C,3,B,5 -> no early abort (digit_idx reaches 3); err pulse of 1 cycle; fail_cnt=1; unlocked stays 0.
- Lockout: three wrong codes (0,0,0,0 each) -> err pulses, fail_cnt=3, alarm=1 for 16 cycles. Strobes during lockout are ignored. Afterwards fail_cnt=0 and ready=1.
- Clear handling: C,3 then clear together with digit_valid (digit A), then C,3,A,5 -> first partial entry discarded, fail_cnt stays 0, lock opens. clear on the 3rd cycle of OPEN -> ENTRY on the next cycle.
- Reset mid-operation: rst_n low during OPEN (cycle 4) and during entry (digit_idx=2) -> all outputs go to reset values immediately, without waiting for a clock edge.
- LOCK_KEY_LOAD_EN: open the lock, then key_we with key_in=16'h1234 -> relock. Entering 4,3,2,1 opens; C,3,A,5 gives err. key_we in ENTRY leaves the key unchanged.

Source files
------------

// File: rtl/code_lock_ctrl_if.sv
// ----------------------------------------------------------------------------
// code_lock_ctrl_if
//
// Purpose : Bundles the keypad-side handshake and the status outputs of the
//           code lock controller so both ends share one typed connection.
//
// Modports:
//   master - keypad/debounce front end: drives digit_valid, digit, clear
//            (and key_we/key_in when built with LOCK_KEY_LOAD_EN), observes
//            ready, unlocked, alarm, err, digit_idx, fail_cnt.
//   slave  - code_lock_ctrl: the mirror image of master.
//
// Build option: LOCK_KEY_LOAD_EN adds key_we / key_in for runtime key loading.
// ----------------------------------------------------------------------------
interface code_lock_ctrl_if #(
    parameter int DIGITS   = 4,
    parameter int MAX_FAIL = 3
);
    localparam int IDX_W  = $clog2(DIGITS);
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);

    logic              digit_valid;
    logic [3:0]        digit;
    logic              clear;
    logic              ready;
    logic              unlocked;
    logic              alarm;
    logic              err;
    logic [IDX_W-1:0]  digit_idx;
    logic [FAIL_W-1:0] fail_cnt;

`ifdef LOCK_KEY_LOAD_EN
    logic                  key_we;
    logic [4*DIGITS-1:0]   key_in;

    modport master (
        output digit_valid, digit, clear, key_we, key_in,
        input  ready, unlocked, alarm, err, digit_idx, fail_cnt
    );

    modport slave (
        input  digit_valid, digit, clear, key_we, key_in,
        output ready, unlocked, alarm, err, digit_idx, fail_cnt
    );
`else
    modport master (
        output digit_valid, digit, clear,
        input  ready, unlocked, alarm, err, digit_idx, fail_cnt
    );

    modport slave (
        input  digit_valid, digit, clear,
        output ready, unlocked, alarm, err, digit_idx, fail_cnt
    );
`endif

endinterface : code_lock_ctrl_if

// File: rtl/code_lock_ctrl.sv
// ----------------------------------------------------------------------------
// code_lock_ctrl
//
// Purpose : Serial code lock. Digits arrive one per digit_valid strobe and are
//           compared nibble by nibble against a stored key through a single
//           4-bit equality comparator. A full match opens the lock for
//           UNLOCK_CYCLES cycles; MAX_FAIL consecutive wrong codes force an
//           alarm lockout of LOCKOUT_CYCLES cycles.
//
// Ports   :
//   clk    - system clock, all state changes on the rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - code_lock_ctrl_if.slave:
//              in : digit_valid, digit[3:0], clear
//                   (key_we, key_in[4*DIGITS-1:0] with LOCK_KEY_LOAD_EN)
//              out: ready, unlocked, alarm, err, digit_idx, fail_cnt
//
// Parameters:
//   DIGITS         code length in nibbles (2..8)
//   KEY            packed key; first entered digit is checked against KEY[3:0]
//   MAX_FAIL       consecutive failures that trigger lockout (>= 1)
//   UNLOCK_CYCLES  cycles the lock stays open
//   LOCKOUT_CYCLES cycles spent in lockout with alarm high
//
// Build option: define LOCK_KEY_LOAD_EN to hold the key in a register that can
//   be rewritten while the lock is open (key_we/key_in). Without it the key is
//   the KEY parameter.
//
// All outputs come straight from flops; none depend combinationally on inputs.
// ----------------------------------------------------------------------------
module code_lock_ctrl #(
    parameter int                  DIGITS         = 4,
    parameter logic [4*DIGITS-1:0] KEY            = 16'h5A3C,
    parameter int                  MAX_FAIL       = 3,
    parameter int                  UNLOCK_CYCLES  = 8,
    parameter int                  LOCKOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    code_lock_ctrl_if.slave   bus
);

    localparam int IDX_W   = $clog2(DIGITS);
    localparam int FAIL_W  = $clog2(MAX_FAIL + 1);
    localparam int T_MAX   = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES
                                                              : LOCKOUT_CYCLES;
    localparam int TIMER_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(DIGITS - 1);
    localparam logic [FAIL_W-1:0]  FAIL_LAST  = FAIL_W'(MAX_FAIL - 1);
    localparam logic [FAIL_W-1:0]  FAIL_FULL  = FAIL_W'(MAX_FAIL);
    localparam logic [TIMER_W-1:0] OPEN_LOAD  = TIMER_W'(UNLOCK_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCK_LOAD  = TIMER_W'(LOCKOUT_CYCLES - 1);

    // One-hot encoding keeps ENTRY/OPEN/LOCKOUT mutually exclusive by design.
    typedef enum logic [2:0] {
        ST_ENTRY   = 3'b001,
        ST_OPEN    = 3'b010,
        ST_LOCKOUT = 3'b100
    } state_e;

    state_e             state;
    logic [IDX_W-1:0]   digit_idx_q;
    logic               match_acc;
    logic [FAIL_W-1:0]  fail_cnt_q;
    logic [TIMER_W-1:0] timer;
    logic               ready_q;
    logic               unlocked_q;
    logic               alarm_q;
    logic               err_q;

    // ------------------------------------------------------------------------
    // Key source and the single nibble comparator
    // ------------------------------------------------------------------------
    logic [4*DIGITS-1:0] key_src;

`ifdef LOCK_KEY_LOAD_EN
    logic [4*DIGITS-1:0] key_reg;
    assign key_src = key_reg;
`else
    assign key_src = KEY;
`endif

    logic [3:0] key_nibs [DIGITS];

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
        assign key_nibs[gi] = key_src[4*gi +: 4];
    end

    logic [3:0] key_nib;
    logic       eq;

    assign key_nib = key_nibs[digit_idx_q];
    assign eq      = (bus.digit == key_nib);

    // Relock request while open: early clear, or a key rewrite when enabled.
`ifdef LOCK_KEY_LOAD_EN
    logic open_exit;
    assign open_exit = bus.clear || bus.key_we;
`else
    logic open_exit;
    assign open_exit = bus.clear;
`endif

    // ------------------------------------------------------------------------
    // Controller FSM with registered outputs
    // ------------------------------------------------------------------------
    // NOTE: every register here uses <= so all updates see pre-edge values;
    // blocking assignments would make later statements read half-updated
    // state and break the flop semantics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_ENTRY;
            digit_idx_q <= '0;
            match_acc   <= 1'b1;
            fail_cnt_q  <= '0;
            timer       <= '0;
            ready_q     <= 1'b1;
            unlocked_q  <= 1'b0;
            alarm_q     <= 1'b0;
            err_q       <= 1'b0;
`ifdef LOCK_KEY_LOAD_EN
            // NOTE: the key register is reset on purpose -- after power-up
            // the lock must answer to the factory KEY, not to random bits.
            key_reg     <= KEY;
`endif
        end else begin
            err_q <= 1'b0;  // err is a single-cycle pulse

            unique case (state)
                ST_ENTRY: begin
                    if (bus.clear) begin
                        // clear wins over a same-cycle strobe; that digit is lost
                        digit_idx_q <= '0;
                        match_acc   <= 1'b1;
                    end else if (bus.digit_valid) begin
                        if (digit_idx_q == LAST_IDX) begin
                            digit_idx_q <= '0;
                            match_acc   <= 1'b1;
                            if (match_acc && eq) begin
                                state      <= ST_OPEN;
                                ready_q    <= 1'b0;
                                unlocked_q <= 1'b1;
                                fail_cnt_q <= '0;
                                timer      <= OPEN_LOAD;
                            end else begin
                                err_q <= 1'b1;
                                if (fail_cnt_q == FAIL_LAST) begin
                                    state      <= ST_LOCKOUT;
                                    ready_q    <= 1'b0;
                                    alarm_q    <= 1'b1;
                                    fail_cnt_q <= FAIL_FULL;
                                    timer      <= LOCK_LOAD;
                                end else begin
                                    fail_cnt_q <= fail_cnt_q + 1'b1;
                                end
                            end
                        end else begin
                            // Mismatches only accumulate; the entry always runs
                            // to the last digit so the wrong position stays hidden.
                            match_acc   <= match_acc & eq;
                            digit_idx_q <= digit_idx_q + 1'b1;
                        end
                    end
                end

                ST_OPEN: begin
`ifdef LOCK_KEY_LOAD_EN
                    if (bus.key_we) begin
                        key_reg <= bus.key_in;
                    end
`endif
                    if (open_exit || timer == '0) begin
                        state       <= ST_ENTRY;
                        ready_q     <= 1'b1;
                        unlocked_q  <= 1'b0;
                        digit_idx_q <= '0;
                        match_acc   <= 1'b1;
                        timer       <= '0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                ST_LOCKOUT: begin
                    if (timer == '0) begin
                        state      <= ST_ENTRY;
                        ready_q    <= 1'b1;
                        alarm_q    <= 1'b0;
                        fail_cnt_q <= '0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                default: begin
                    // Unreachable encodings fall back to a clean, locked entry.
                    state       <= ST_ENTRY;
                    digit_idx_q <= '0;
                    match_acc   <= 1'b1;
                    timer       <= '0;
                    ready_q     <= 1'b1;
                    unlocked_q  <= 1'b0;
                    alarm_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready     = ready_q;
    assign bus.unlocked  = unlocked_q;
    assign bus.alarm     = alarm_q;
    assign bus.err       = err_q;
    assign bus.digit_idx = digit_idx_q;
    assign bus.fail_cnt  = fail_cnt_q;

endmodule : code_lock_ctrl

// File: tb/tb_code_lock_ctrl.sv
// ----------------------------------------------------------------------------
// tb_code_lock_ctrl
//
// Directed bench for code_lock_ctrl with default parameters. Stimulus pushes
// expected output windows (err / unlocked / alarm: start cycle and length)
// into a queue; a monitor watching the DUT outputs pops and compares each
// window when it closes. Direct status checks cover reset values, digit_idx
// and fail_cnt at chosen points.
// ----------------------------------------------------------------------------
module tb_code_lock_ctrl;

    localparam int DIGITS         = 4;
    localparam int MAX_FAIL       = 3;
    localparam int UNLOCK_CYCLES  = 8;
    localparam int LOCKOUT_CYCLES = 16;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    code_lock_ctrl_if #(.DIGITS(DIGITS), .MAX_FAIL(MAX_FAIL)) lif ();

    code_lock_ctrl #(
        .DIGITS        (DIGITS),
        .KEY           (16'h5A3C),
        .MAX_FAIL      (MAX_FAIL),
        .UNLOCK_CYCLES (UNLOCK_CYCLES),
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (lif)
    );

    typedef enum int {EV_ERR = 0, EV_OPEN = 1, EV_ALARM = 2} ev_kind_e;

    typedef struct {
        ev_kind_e kind;
        int       start;
        int       len;
    } ev_t;

    ev_t exp_q[$];

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int last_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_ev(input ev_kind_e kind, input int start, input int len);
        ev_t e;
        e.kind  = kind;
        e.start = start;
        e.len   = len;
        exp_q.push_back(e);
    endtask

    // ------------------------------------------------------------------------
    // Monitor: measures each err/unlocked/alarm window, compares on its close
    // ------------------------------------------------------------------------
    bit cur  [3];
    bit prev [3] = '{1'b0, 1'b0, 1'b0};
    int st   [3];
    int ln   [3];

    task automatic report(input int k, input int start, input int len);
        ev_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_miss++;
            $display("FAIL unexpected_window: kind %0d start %0d len %0d, none expected",
                     k, start, len);
        end else begin
            e = exp_q.pop_front();
            if (int'(e.kind) != k || e.start != start || e.len != len) begin
                n_miss++;
                $display("FAIL window: got kind %0d start %0d len %0d, expected kind %0d start %0d len %0d",
                         k, start, len, int'(e.kind), e.start, e.len);
            end
        end
    endtask

    always @(negedge clk) begin
        cur[0] = (lif.err === 1'b1);
        cur[1] = (lif.unlocked === 1'b1);
        cur[2] = (lif.alarm === 1'b1);
        for (int k = 0; k < 3; k++) begin
            if (cur[k]) begin
                if (!prev[k]) begin
                    st[k] = cyc;
                    ln[k] = 0;
                end
                ln[k]++;
            end else if (prev[k]) begin
                report(k, st[k], ln[k]);
            end
            prev[k] = cur[k];
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic strobe(input logic [3:0] d, input logic clr);
        @(negedge clk);
        lif.digit_valid = 1'b1;
        lif.digit       = d;
        lif.clear       = clr;
        @(negedge clk);
        lif.digit_valid = 1'b0;
        lif.clear       = 1'b0;
        last_cyc        = cyc;
    endtask

    task automatic enter4(input logic [3:0] d0, input logic [3:0] d1,
                          input logic [3:0] d2, input logic [3:0] d3);
        strobe(d0, 1'b0);
        strobe(d1, 1'b0);
        strobe(d2, 1'b0);
        strobe(d3, 1'b0);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending_windows", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},     lif.ready,     1);
        check({tag, "_unlocked"},  lif.unlocked,  0);
        check({tag, "_alarm"},     lif.alarm,     0);
        check({tag, "_err"},       lif.err,       0);
        check({tag, "_digit_idx"}, lif.digit_idx, 0);
        check({tag, "_fail_cnt"},  lif.fail_cnt,  0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        lif.digit_valid = 1'b0;
        lif.digit       = 4'h0;
        lif.clear       = 1'b0;
`ifdef LOCK_KEY_LOAD_EN
        lif.key_we      = 1'b0;
        lif.key_in      = '0;
`endif
        rst_n = 1'b0;
        #23;
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check_reset_outputs("reset");

        // Correct code C,3,A,5: open one cycle after 4th strobe, 8 cycles
        strobe(4'hC, 1'b0);
        strobe(4'h3, 1'b0);
        strobe(4'hA, 1'b0);
        check("good_idx_before_last", lif.digit_idx, 3);
        strobe(4'h5, 1'b0);
        expect_ev(EV_OPEN, last_cyc, UNLOCK_CYCLES);
        check("good_unlocked_now", lif.unlocked, 1);
        check("good_ready_low", lif.ready, 0);
        wait_idle(40);
        check("good_after_ready", lif.ready, 1);
        check("good_after_idx", lif.digit_idx, 0);

        // Single wrong digit C,3,B,5: no early abort, one-cycle err
        strobe(4'hC, 1'b0);
        strobe(4'h3, 1'b0);
        strobe(4'hB, 1'b0);
        check("wrong_idx_no_abort", lif.digit_idx, 3);
        check("wrong_still_locked", lif.unlocked, 0);
        strobe(4'h5, 1'b0);
        expect_ev(EV_ERR, last_cyc, 1);
        check("wrong_fail_cnt", lif.fail_cnt, 1);
        check("wrong_ready", lif.ready, 1);
        wait_idle(10);

        // Async reset mid-entry (fail_cnt=1, digit_idx=2)
        strobe(4'hC, 1'b0);
        strobe(4'h3, 1'b0);
        check("midentry_idx", lif.digit_idx, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_entry");
        @(negedge clk);
        rst_n = 1'b1;

        // Lockout after three wrong codes
        enter4(4'h0, 4'h0, 4'h0, 4'h0);
        expect_ev(EV_ERR, last_cyc, 1);
        check("lock_fail1", lif.fail_cnt, 1);
        enter4(4'h0, 4'h0, 4'h0, 4'h0);
        expect_ev(EV_ERR, last_cyc, 1);
        check("lock_fail2", lif.fail_cnt, 2);
        enter4(4'h0, 4'h0, 4'h0, 4'h0);
        expect_ev(EV_ERR, last_cyc, 1);
        expect_ev(EV_ALARM, last_cyc, LOCKOUT_CYCLES);
        check("lock_fail3", lif.fail_cnt, 3);
        check("lock_alarm", lif.alarm, 1);
        check("lock_ready_low", lif.ready, 0);
        strobe(4'hC, 1'b0);
        strobe(4'h3, 1'b1);
        check("lock_strobe_ignored_idx", lif.digit_idx, 0);
        check("lock_strobe_ignored_fail", lif.fail_cnt, 3);
        wait_idle(40);
        check("lock_after_fail", lif.fail_cnt, 0);
        check("lock_after_ready", lif.ready, 1);
        check("lock_after_alarm", lif.alarm, 0);

        // Clear with a same-cycle strobe drops the digit and the partial entry
        strobe(4'hC, 1'b0);
        strobe(4'h3, 1'b0);
        strobe(4'hA, 1'b1);
        check("clear_idx", lif.digit_idx, 0);
        check("clear_fail", lif.fail_cnt, 0);
        enter4(4'hC, 4'h3, 4'hA, 4'h5);
        // clear during the 3rd open cycle -> 3 cycles of unlocked
        expect_ev(EV_OPEN, last_cyc, 3);
        @(negedge clk);
        @(negedge clk);
        lif.clear = 1'b1;
        @(negedge clk);
        lif.clear = 1'b0;
        check("clear_open_relock_ready", lif.ready, 1);
        check("clear_open_relock_unl", lif.unlocked, 0);
        wait_idle(10);

        // Async reset in the 4th open cycle
        enter4(4'hC, 4'h3, 4'hA, 4'h5);
        expect_ev(EV_OPEN, last_cyc, 4);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_open");
        @(negedge clk);
        rst_n = 1'b1;
        wait_idle(10);

`ifdef LOCK_KEY_LOAD_EN
        // Key rewrite while open relocks on the following cycle
        enter4(4'hC, 4'h3, 4'hA, 4'h5);
        expect_ev(EV_OPEN, last_cyc, 2);
        @(negedge clk);
        lif.key_we = 1'b1;
        lif.key_in = 16'h1234;
        @(negedge clk);
        lif.key_we = 1'b0;
        check("keyload_relock", lif.ready, 1);
        wait_idle(10);
        enter4(4'h4, 4'h3, 4'h2, 4'h1);
        expect_ev(EV_OPEN, last_cyc, UNLOCK_CYCLES);
        wait_idle(40);
        enter4(4'hC, 4'h3, 4'hA, 4'h5);
        expect_ev(EV_ERR, last_cyc, 1);
        check("keyload_old_key_fails", lif.fail_cnt, 1);
        wait_idle(10);
        // key_we in ENTRY must not change the key
        @(negedge clk);
        lif.key_we = 1'b1;
        lif.key_in = 16'hFFFF;
        @(negedge clk);
        lif.key_we = 1'b0;
        enter4(4'h4, 4'h3, 4'h2, 4'h1);
        expect_ev(EV_OPEN, last_cyc, UNLOCK_CYCLES);
        check("keyload_entry_ignored", lif.unlocked, 1);
        wait_idle(40);
`endif

        wait_idle(50);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_code_lock_ctrl
